// File: rtl/bram_arb_pkg.sv
// Shared constants, FSM state type and write-command payload for the BRAM arbiter.
package bram_arb_pkg;

    localparam int unsigned DATA_W            = 16;
    localparam int unsigned ADDR_W            = 16;
    localparam int unsigned ADDR_BITS_DEFAULT = 14;

    // Requester indices
    localparam int unsigned FETCH  = 0;
    localparam int unsigned DATA   = 1;
    localparam int unsigned LOADER = 2;

    typedef enum logic [1:0] {
        OPEN   = 2'd0,
        DRAIN  = 2'd1,
        LOCKED = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_cmd_t;

endpackage

// File: rtl/bram_arb_if.sv
// Requester handshakes plus the BRAM-side strobes of the arbiter, bundled as one interface.
interface bram_arb_if;
    import bram_arb_pkg::*;

    logic              f_req;
    logic [ADDR_W-1:0] f_addr;
    logic              f_gnt;
    logic              f_rvalid;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;

    logic              l_req;
    logic [ADDR_W-1:0] l_addr;
    logic [DATA_W-1:0] l_wdata;
    logic              l_gnt;
    logic              l_lock;
    logic              l_lock_ack;

    logic [DATA_W-1:0] rdata;

    logic              mem_wren_n;
    logic              mem_oen_n;
    logic [ADDR_W-1:0] mem_rdaddress;
    logic [ADDR_W-1:0] mem_wraddress;
    logic [DATA_W-1:0] mem_data_in;
    logic [DATA_W-1:0] mem_data_out;

    modport slave (
        input  f_req, f_addr, d_req, d_we, d_addr, d_wdata,
               l_req, l_addr, l_wdata, l_lock, mem_data_out,
        output f_gnt, f_rvalid, d_gnt, d_rvalid, l_gnt, l_lock_ack, rdata,
               mem_wren_n, mem_oen_n, mem_rdaddress, mem_wraddress, mem_data_in
    );

    modport master (
        output f_req, f_addr, d_req, d_we, d_addr, d_wdata,
               l_req, l_addr, l_wdata, l_lock, mem_data_out,
        input  f_gnt, f_rvalid, d_gnt, d_rvalid, l_gnt, l_lock_ack, rdata,
               mem_wren_n, mem_oen_n, mem_rdaddress, mem_wraddress, mem_data_in
    );

endinterface

// File: rtl/bram_arb_slot.sv
// Two-candidate picker: candidate 1 wins by default; a masked winner is simply not granted.
// With BRAM_ARB_RR_EN defined the preference toggles after every contested grant.
module bram_arb_slot (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic [1:0] mask,
    output logic [1:0] gnt
);

    logic       ptr_q;
    logic       ptr_d;
    logic [1:0] pick;

    // Winner is chosen before masking so a blocked winner is never replaced
    always_comb begin
        pick = req;
        if (req == 2'b11) begin
            pick = ptr_q ? 2'b10 : 2'b01;
        end
    end

    assign gnt = pick & ~mask;

    always_comb begin
        ptr_d = ptr_q;
`ifdef BRAM_ARB_RR_EN
        if ((req == 2'b11) && (gnt != 2'b00)) begin
            ptr_d = ~ptr_q;
        end
`else
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= 1'b1;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/bram_arbiter.sv
// Shares one BRAM (1 registered read port, 1 write port) between fetch, data port and loader.
// Optional BRAM_ARB_RR_EN turns both slot pickers into round-robin.
module bram_arbiter
    import bram_arb_pkg::*;
#(
    parameter int unsigned ADDR_BITS = ADDR_BITS_DEFAULT
) (
    input  logic      clk,
    input  logic      rst_n,
    bram_arb_if.slave bus
);

    localparam logic [ADDR_W-1:0] AMASK = ADDR_W'((64'd1 << ADDR_BITS) - 64'd1);

    arb_state_e        state_q;
    arb_state_e        state_d;
    logic              cpu_en_c;
    logic              lock_ack_c;

    logic [ADDR_W-1:0] f_addr_m;
    logic [ADDR_W-1:0] d_addr_m;
    logic [ADDR_W-1:0] l_addr_m;
    logic [ADDR_W-1:0] rd_addr_m;
    wr_cmd_t           wr_cmd;

    logic [1:0]        rd_req;
    logic [1:0]        rd_mask;
    logic [1:0]        rd_gnt;
    logic [1:0]        wr_req;
    logic [1:0]        wr_gnt;

    logic              f_pend_q;
    logic              d_pend_q;
    logic [DATA_W-1:0] rdata_q;

    assign f_addr_m = bus.f_addr & AMASK;
    assign d_addr_m = bus.d_addr & AMASK;
    assign l_addr_m = bus.l_addr & AMASK;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= OPEN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            OPEN:    if (bus.l_lock) state_d = DRAIN;
            DRAIN:   state_d = bus.l_lock ? LOCKED : OPEN;
            LOCKED:  if (!bus.l_lock) state_d = OPEN;
            default: state_d = OPEN;
        endcase
    end

    // CPU ports are shut off as soon as a lock is requested
    always_comb begin
        cpu_en_c   = 1'b0;
        lock_ack_c = 1'b0;
        case (state_q)
            OPEN:    cpu_en_c = rst_n & ~bus.l_lock;
            LOCKED:  lock_ack_c = 1'b1;
            default: ;
        endcase
    end

    // Write slot: candidate 1 = loader, candidate 0 = data port
    assign wr_req = {rst_n & bus.l_req, cpu_en_c & bus.d_req & bus.d_we};

    bram_arb_slot u_wr_slot (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (wr_req),
        .mask  (2'b00),
        .gnt   (wr_gnt)
    );

    always_comb begin
        wr_cmd = '0;
        if (wr_gnt[1]) begin
            wr_cmd.addr = l_addr_m;
            wr_cmd.data = bus.l_wdata;
        end else if (wr_gnt[0]) begin
            wr_cmd.addr = d_addr_m;
            wr_cmd.data = bus.d_wdata;
        end
    end

    // Read slot: candidate 1 = data port, candidate 0 = fetch; blocked on write-address match
    assign rd_req  = {cpu_en_c & bus.d_req & ~bus.d_we, cpu_en_c & bus.f_req};
    assign rd_mask = {(|wr_gnt) & (d_addr_m == wr_cmd.addr),
                      (|wr_gnt) & (f_addr_m == wr_cmd.addr)};

    bram_arb_slot u_rd_slot (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (rd_req),
        .mask  (rd_mask),
        .gnt   (rd_gnt)
    );

    assign rd_addr_m = rd_gnt[1] ? d_addr_m : (rd_gnt[0] ? f_addr_m : '0);

    // Read-owner tracking and rdata hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f_pend_q <= 1'b0;
            d_pend_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            f_pend_q <= rd_gnt[0];
            d_pend_q <= rd_gnt[1];
            if (f_pend_q | d_pend_q) begin
                rdata_q <= bus.mem_data_out;
            end
        end
    end

    assign bus.f_gnt         = rd_gnt[0];
    assign bus.d_gnt         = rd_gnt[1] | wr_gnt[0];
    assign bus.l_gnt         = wr_gnt[1];
    assign bus.f_rvalid      = f_pend_q;
    assign bus.d_rvalid      = d_pend_q;
    assign bus.l_lock_ack    = lock_ack_c;
    assign bus.rdata         = (f_pend_q | d_pend_q) ? bus.mem_data_out : rdata_q;
    assign bus.mem_oen_n     = ~(|rd_gnt);
    assign bus.mem_wren_n    = ~(|wr_gnt);
    assign bus.mem_rdaddress = rd_addr_m;
    assign bus.mem_wraddress = wr_cmd.addr;
    assign bus.mem_data_in   = wr_cmd.data;

endmodule

// File: tb/tb_bram_arbiter.sv
// Self-checking bench for bram_arbiter: directed scenarios plus randomized traffic against a behavioural model.
module tb_bram_arbiter;
    import bram_arb_pkg::*;

    localparam int unsigned AB    = ADDR_BITS_DEFAULT;
    localparam int unsigned DEPTH = 1 << AB;
    localparam logic [15:0] M     = 16'((32'd1 << AB) - 32'd1);

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    bram_arb_if bus ();

    bram_arbiter #(.ADDR_BITS(AB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] init_val(input int unsigned a);
        if (a == 16) return 16'h1234;
        return 16'((a * 32'd257) ^ 32'h5A00);
    endfunction

    // BRAM with a registered read port
    logic [15:0] bram [DEPTH];
    bit          loaded = 1'b0;
    always @(posedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < DEPTH; i++) bram[i] = init_val(i);
            loaded = 1'b1;
        end
        if (!bus.mem_oen_n)  bus.mem_data_out <= bram[bus.mem_rdaddress[AB-1:0]];
        if (!bus.mem_wren_n) bram[bus.mem_wraddress[AB-1:0]] = bus.mem_data_in;
    end

    // Behavioural model state
    logic [15:0] ref_mem [DEPTH];
    int          lock_run;
    bit          rd_pref_d, wr_pref_l;
    bit          exp_frv, exp_drv;
    logic [15:0] exp_rdata;
    bit          e_fg, e_dg, e_lg, e_rd, e_wr, e_rd_is_d, rd_contest, wr_contest;
    logic [15:0] e_raddr, e_waddr, e_wdata;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_frv   = 1'b0;
        exp_drv   = 1'b0;
        exp_rdata = 16'h0;
        lock_run  = 0;
        rd_pref_d = 1'b1;
        wr_pref_l = 1'b1;
    endtask

    task automatic model_eval();
        bit cpu_ok, lw, dw, dr, fr, wd, pick_d, pick_f, blocked;
        logic [15:0] paddr;
        cpu_ok     = rst_n && (lock_run == 0) && !bus.l_lock;
        lw         = rst_n && bus.l_req;
        dw         = cpu_ok && bus.d_req && bus.d_we;
        dr         = cpu_ok && bus.d_req && !bus.d_we;
        fr         = cpu_ok && bus.f_req;
        wr_contest = lw && dw;
        rd_contest = dr && fr;
        e_lg       = lw && (!dw || wr_pref_l);
        wd         = dw && !e_lg;
        e_wr       = e_lg || wd;
        e_waddr    = e_lg ? (bus.l_addr & M) : (wd ? (bus.d_addr & M) : 16'h0);
        e_wdata    = e_lg ? bus.l_wdata : (wd ? bus.d_wdata : 16'h0);
        pick_d     = dr && (!fr || rd_pref_d);
        pick_f     = fr && !pick_d;
        paddr      = pick_d ? (bus.d_addr & M) : (bus.f_addr & M);
        blocked    = e_wr && (pick_d || pick_f) && (paddr == e_waddr);
        e_rd       = (pick_d || pick_f) && !blocked;
        e_rd_is_d  = pick_d;
        e_fg       = pick_f && !blocked;
        e_dg       = wd || (pick_d && !blocked);
        e_raddr    = e_rd ? paddr : 16'h0;
    endtask

    // Compare all DUT outputs against the model, away from the active edge
    task automatic settle();
        @(negedge clk);
        model_eval();
        chk("f_gnt",         16'(bus.f_gnt),      16'(e_fg));
        chk("d_gnt",         16'(bus.d_gnt),      16'(e_dg));
        chk("l_gnt",         16'(bus.l_gnt),      16'(e_lg));
        chk("f_rvalid",      16'(bus.f_rvalid),   16'(exp_frv));
        chk("d_rvalid",      16'(bus.d_rvalid),   16'(exp_drv));
        chk("l_lock_ack",    16'(bus.l_lock_ack), 16'(lock_run >= 2));
        chk("rdata",         bus.rdata,           exp_rdata);
        chk("mem_oen_n",     16'(bus.mem_oen_n),  16'(!e_rd));
        chk("mem_wren_n",    16'(bus.mem_wren_n), 16'(!e_wr));
        chk("mem_rdaddress", bus.mem_rdaddress,   e_raddr);
        chk("mem_wraddress", bus.mem_wraddress,   e_waddr);
        chk("mem_data_in",   bus.mem_data_in,     e_wdata);
    endtask

    // Apply the effect of the coming rising edge to the model, then step past it
    task automatic adv();
        if (rst_n) begin
            exp_frv = e_fg;
            exp_drv = e_rd && e_rd_is_d;
            if (e_rd) exp_rdata = ref_mem[e_raddr[AB-1:0]];
            if (e_wr) ref_mem[e_waddr[AB-1:0]] = e_wdata;
            lock_run = bus.l_lock ? ((lock_run < 2) ? lock_run + 1 : 2) : 0;
`ifdef BRAM_ARB_RR_EN
            if (rd_contest && e_rd) rd_pref_d = !rd_pref_d;
            if (wr_contest && e_wr) wr_pref_l = !wr_pref_l;
`endif
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.f_req = 1'b0; bus.d_req = 1'b0; bus.l_req = 1'b0;
    endtask

    function automatic logic [15:0] rnd_addr();
        return 16'($urandom_range(0, 3) << 14) | 16'(32'h10 + $urandom_range(0, 7));
    endfunction

    task automatic drive_random();
        if (!bus.f_req || e_fg) begin
            bus.f_req  = ($urandom_range(0, 99) < 60);
            bus.f_addr = rnd_addr();
        end
        if (!bus.d_req || e_dg) begin
            bus.d_req   = ($urandom_range(0, 99) < 50);
            bus.d_we    = 1'($urandom_range(0, 1));
            bus.d_addr  = rnd_addr();
            bus.d_wdata = 16'($urandom);
        end
        if (!bus.l_req || e_lg) begin
            bus.l_req   = ($urandom_range(0, 99) < 20);
            bus.l_addr  = rnd_addr();
            bus.l_wdata = 16'($urandom);
        end
        if ($urandom_range(0, 99) < 4) bus.l_lock = !bus.l_lock;
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_val(i);
        bus.f_req = 0; bus.f_addr = 0;
        bus.d_req = 0; bus.d_we = 0; bus.d_addr = 0; bus.d_wdata = 0;
        bus.l_req = 0; bus.l_addr = 0; bus.l_wdata = 0; bus.l_lock = 0;
        model_reset();

        // Reset values
        settle();
        chk("rst oen", 16'(bus.mem_oen_n), 16'd1);
        chk("rst rdata", bus.rdata, 16'h0000);
        adv(); adv();
        rst_n = 1'b1;

        // Fetch from preloaded location
        bus.f_req = 1; bus.f_addr = 16'h0010;
        settle(); chk("T1 f_gnt", 16'(bus.f_gnt), 16'd1); chk("T1 oen", 16'(bus.mem_oen_n), 16'd0);
        adv(); idle();
        settle(); chk("T1 f_rvalid", 16'(bus.f_rvalid), 16'd1); chk("T1 rdata", bus.rdata, 16'h1234);
        adv();

        // Concurrent data write and fetch read
        bus.d_req = 1; bus.d_we = 1; bus.d_addr = 16'h0020; bus.d_wdata = 16'hBEEF;
        bus.f_req = 1; bus.f_addr = 16'h0030;
        settle(); chk("T2 d_gnt", 16'(bus.d_gnt), 16'd1); chk("T2 f_gnt", 16'(bus.f_gnt), 16'd1);
        chk("T2 wren", 16'(bus.mem_wren_n), 16'd0); chk("T2 oen", 16'(bus.mem_oen_n), 16'd0);
        adv(); idle();
        bus.f_req = 1; bus.f_addr = 16'h0020;
        settle(); adv(); idle();
        settle(); chk("T2 readback", bus.rdata, 16'hBEEF);
        adv();

        // Two reads contend: data first, fetch next cycle
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 16'h0040;
        bus.f_req = 1; bus.f_addr = 16'h0041;
        settle(); chk("T3 d_gnt", 16'(bus.d_gnt), 16'd1); chk("T3 f_gnt", 16'(bus.f_gnt), 16'd0);
        adv(); bus.d_req = 0;
        settle(); chk("T3 f_gnt2", 16'(bus.f_gnt), 16'd1); chk("T3 d_rvalid", 16'(bus.d_rvalid), 16'd1);
        adv(); idle();
        settle(); chk("T3 f_rvalid", 16'(bus.f_rvalid), 16'd1);
        adv();

        // Same-address write blocks the read for one cycle
        bus.l_req = 1; bus.l_addr = 16'h0050; bus.l_wdata = 16'hCAFE;
        bus.f_req = 1; bus.f_addr = 16'h0050;
        settle(); chk("T4 l_gnt", 16'(bus.l_gnt), 16'd1); chk("T4 f_gnt", 16'(bus.f_gnt), 16'd0);
        adv(); bus.l_req = 0;
        settle(); chk("T4 f_gnt2", 16'(bus.f_gnt), 16'd1);
        adv(); idle();
        settle(); chk("T4 rdata", bus.rdata, 16'hCAFE);
        adv();

        // Lock with a fetch outstanding
        bus.f_req = 1; bus.f_addr = 16'h0010;
        settle(); chk("T5 f_gnt", 16'(bus.f_gnt), 16'd1);
        adv(); bus.f_addr = 16'h0011; bus.l_lock = 1;
        settle(); chk("T5 f_rvalid", 16'(bus.f_rvalid), 16'd1); chk("T5 f_gnt off", 16'(bus.f_gnt), 16'd0);
        chk("T5 ack0", 16'(bus.l_lock_ack), 16'd0);
        adv();
        settle(); chk("T5 drain ack", 16'(bus.l_lock_ack), 16'd0);
        adv(); bus.l_req = 1; bus.l_addr = 16'h0060; bus.l_wdata = 16'h7777;
        settle(); chk("T5 ack1", 16'(bus.l_lock_ack), 16'd1); chk("T5 l_gnt", 16'(bus.l_gnt), 16'd1);
        chk("T5 f_held", 16'(bus.f_gnt), 16'd0);
        adv(); bus.l_req = 0; bus.l_lock = 0;
        settle(); chk("T5 ack still", 16'(bus.l_lock_ack), 16'd1); chk("T5 f_still", 16'(bus.f_gnt), 16'd0);
        adv();
        settle(); chk("T5 ack fall", 16'(bus.l_lock_ack), 16'd0); chk("T5 f_resume", 16'(bus.f_gnt), 16'd1);
        adv(); idle();

        // Reset right after a read is granted
        bus.f_req = 1; bus.f_addr = 16'h0010;
        settle(); chk("T6 f_gnt", 16'(bus.f_gnt), 16'd1);
        adv(); rst_n = 1'b0; model_reset();
        settle(); chk("T6 f_rvalid", 16'(bus.f_rvalid), 16'd0); chk("T6 rdata", bus.rdata, 16'h0000);
        chk("T6 oen", 16'(bus.mem_oen_n), 16'd1); chk("T6 wren", 16'(bus.mem_wren_n), 16'd1);
        adv(); rst_n = 1'b1;
        settle(); chk("T6 open", 16'(bus.f_gnt), 16'd1);
        adv(); idle();

        // Continuous data read against fetch
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 16'h0012;
        bus.f_req = 1; bus.f_addr = 16'h0013;
        for (int k = 0; k < 4; k++) begin
            settle();
`ifdef BRAM_ARB_RR_EN
            chk("T7 d_gnt", 16'(bus.d_gnt), 16'((k % 2) == 0));
`else
            chk("T7 d_gnt", 16'(bus.d_gnt), 16'd1);
`endif
            adv();
        end
        idle();

        // Randomized traffic, with occasional resets
        for (int i = 0; i < 3000; i++) begin
            drive_random();
            if ((i % 1000) == 500) begin
                rst_n = 1'b0;
                model_reset();
                settle();
                adv();
                rst_n = 1'b1;
            end else begin
                settle();
                adv();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
